mopshub_bus_power_seq: RTL and testbench

Power-up and oscillator-trim sequencer for the MOPSHUB CAN buses. On an initialization request it walks bus indices 0..n_buses in turn. For each bus it enables power, waits for supply settle, pulses the bus reset, and optionally requests and awaits an oscillator trim. It sits between the hub init FSM (start_init / end_power_init) and the power-SPI, bus-reset and trim logic. It drives power_bus_cnt, power_bus_en, rst_bus and start_trim_ack.

---
 rtl/mopshub_bus_power_seq.sv | 170 +++++++++++++++++
 tb/tb_mopshub_bus_power_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mopshub_bus_power_seq.sv
// Power-up and oscillator-trim sequencer for the MOPSHUB CAN buses.
// Walks bus indices 0..last. For each bus it enables power, waits for the
// supply to settle, pulses the bus reset and optionally runs a trim handshake.
// All outputs come straight from registers.
module mopshub_bus_power_seq #(
    parameter int unsigned MAX_BUSES     = 16,
    parameter int unsigned CNT_W         = 5,
    parameter int unsigned SETTLE_CYCLES = 4000,
    parameter int unsigned RST_CYCLES    = 40,
    parameter int unsigned TRIM_TIMEOUT  = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_init_i,
    input  logic                 abort_i,
    input  logic [CNT_W-1:0]     n_buses_i,
    input  logic                 osc_auto_trim_i,
    input  logic                 end_trim_bus_i,
    output logic [CNT_W-1:0]     power_bus_cnt_o,
    output logic                 power_bus_en_o,
    output logic [MAX_BUSES-1:0] power_mask_o,
    output logic                 rst_bus_o,
    output logic                 start_trim_ack_o,
    output logic [MAX_BUSES-1:0] bus_fail_mask_o,
    output logic                 busy_o,
    output logic                 end_power_init_o
);

    // One shared timer serves SETTLE, RESET_BUS and TRIM_WAIT.
    localparam int unsigned TMaxA = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
    localparam int unsigned TMax  = (TMaxA > TRIM_TIMEOUT) ? TMaxA : TRIM_TIMEOUT;
    localparam int unsigned TW    = $clog2(TMax + 1);

    localparam logic [CNT_W-1:0]     LastMax = CNT_W'(MAX_BUSES - 1);
    localparam logic [MAX_BUSES-1:0] OneBit  = MAX_BUSES'(1);

    typedef enum logic [2:0] {
        StIdle, StPowerOn, StSettle, StResetBus, StTrimReq, StTrimWait, StNext, StDone
    } state_e;

    state_e               state_q;
    logic [TW-1:0]        timer_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     last_q;
    logic                 trim_en_q;
    logic                 en_q;
    logic                 rst_bus_q;
    logic                 ack_q;
    logic                 busy_q;
    logic                 end_q;
    logic [MAX_BUSES-1:0] power_mask_q;
    logic [MAX_BUSES-1:0] fail_mask_q;

    // Sequencer FSM; every output is registered on the transition into its state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            cnt_q        <= '0;
            last_q       <= '0;
            trim_en_q    <= 1'b0;
            en_q         <= 1'b0;
            rst_bus_q    <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            end_q        <= 1'b0;
            power_mask_q <= '0;
            fail_mask_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            end_q <= 1'b0;
            if (abort_i && (state_q != StIdle)) begin
                // Abort drops power state but keeps the record of failed trims.
                state_q      <= StIdle;
                en_q         <= 1'b0;
                rst_bus_q    <= 1'b0;
                busy_q       <= 1'b0;
                power_mask_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_init_i) begin
                            last_q       <= (n_buses_i > LastMax) ? LastMax : n_buses_i;
                            trim_en_q    <= osc_auto_trim_i;
                            cnt_q        <= '0;
                            fail_mask_q  <= '0;
                            power_mask_q <= OneBit;
                            en_q         <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= StPowerOn;
                        end
                    end
                    StPowerOn: begin
                        timer_q <= '0;
                        state_q <= StSettle;
                    end
                    StSettle: begin
                        if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
                            timer_q   <= '0;
                            rst_bus_q <= 1'b1;
                            state_q   <= StResetBus;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    StResetBus: begin
                        if (timer_q == TW'(RST_CYCLES - 1)) begin
                            timer_q   <= '0;
                            rst_bus_q <= 1'b0;
                            ack_q     <= trim_en_q;
                            state_q   <= StTrimReq;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    StTrimReq: begin
                        timer_q <= '0;
                        if (trim_en_q) begin
                            state_q <= StTrimWait;
                        end else begin
                            en_q    <= 1'b0;
                            state_q <= StNext;
                        end
                    end
                    StTrimWait: begin
                        // A completion on the timeout cycle counts as success.
                        if (end_trim_bus_i) begin
                            en_q    <= 1'b0;
                            state_q <= StNext;
                        end else if (timer_q == TW'(TRIM_TIMEOUT)) begin
                            fail_mask_q <= fail_mask_q | (OneBit << cnt_q);
                            en_q        <= 1'b0;
                            state_q     <= StNext;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    StNext: begin
                        if (cnt_q == last_q) begin
                            end_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cnt_q        <= cnt_q + CNT_W'(1);
                            power_mask_q <= power_mask_q | (OneBit << (cnt_q + CNT_W'(1)));
                            en_q         <= 1'b1;
                            state_q      <= StPowerOn;
                        end
                    end
                    StDone: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign power_bus_cnt_o  = cnt_q;
    assign power_bus_en_o   = en_q;
    assign power_mask_o     = power_mask_q;
    assign rst_bus_o        = rst_bus_q;
    assign start_trim_ack_o = ack_q;
    assign bus_fail_mask_o  = fail_mask_q;
    assign busy_o           = busy_q;
    assign end_power_init_o = end_q;

endmodule

// File: tb/tb_mopshub_bus_power_seq.sv
// Bench for mopshub_bus_power_seq: a table of directed runs plus randomized
// runs, each checked cycle by cycle against a timeline model built from the
// per-bus phase lengths.
module tb_mopshub_bus_power_seq;

    localparam int MB = 16;
    localparam int CW = 5;
    localparam int S  = 4;
    localparam int R  = 2;
    localparam int TO = 20;
    localparam int NC = 640;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_init = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] n_buses = '0;
    logic          osc = 1'b0;
    logic          end_trim = 1'b0;
    logic [CW-1:0] power_bus_cnt;
    logic          power_bus_en;
    logic [MB-1:0] power_mask;
    logic          rst_bus;
    logic          start_trim_ack;
    logic [MB-1:0] bus_fail_mask;
    logic          busy;
    logic          end_power_init;

    mopshub_bus_power_seq #(
        .MAX_BUSES    (MB),
        .CNT_W        (CW),
        .SETTLE_CYCLES(S),
        .RST_CYCLES   (R),
        .TRIM_TIMEOUT (TO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_init_i    (start_init),
        .abort_i         (abort),
        .n_buses_i       (n_buses),
        .osc_auto_trim_i (osc),
        .end_trim_bus_i  (end_trim),
        .power_bus_cnt_o (power_bus_cnt),
        .power_bus_en_o  (power_bus_en),
        .power_mask_o    (power_mask),
        .rst_bus_o       (rst_bus),
        .start_trim_ack_o(start_trim_ack),
        .bus_fail_mask_o (bus_fail_mask),
        .busy_o          (busy),
        .end_power_init_o(end_power_init)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected waveforms; -1 marks a don't-care cycle.
    // 0 en, 1 rst_bus, 2 ack, 3 busy, 4 end, 5 cnt, 6 power_mask, 7 fail_mask
    int m_exp[8][NC];
    bit m_wait[NC];
    bit m_tin[NC];
    bit m_spst[NC];
    int m_done;
    int d_of[MB];  // trim response delay after ack per bus, 0 = never
    string sig_name[8] = '{"en", "rst_bus", "ack", "busy", "end", "cnt", "pmask", "fmask"};

    typedef struct {
        int nb; bit trim; int d0; int drest; int none_mask; bit spt; bit sps; int abort_at;
        int exp_done; int exp_pm; int exp_fm; int exp_ack;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lay out each bus as consecutive phases: POWER_ON, SETTLE, RESET_BUS,
    // TRIM_REQ, optional TRIM_WAIT, NEXT; then DONE.
    task automatic build_model(input int nb, input bit trim, input bit spt, input bit sps);
        int last;
        int c;
        int pm;
        int fm;
        last = (nb > MB - 1) ? MB - 1 : nb;
        for (int t = 0; t < NC; t++) begin
            for (int i = 0; i < 8; i++) m_exp[i][t] = 0;
            m_wait[t] = 0;
            m_tin[t]  = 0;
            m_spst[t] = 0;
        end
        c  = 1;
        pm = 0;
        fm = 0;
        for (int b = 0; b <= last; b++) begin
            bit ok;
            int w;
            int dur;
            ok  = (d_of[b] >= 1) && (d_of[b] <= TO + 1);
            w   = ok ? d_of[b] : TO + 1;
            dur = S + R + 3 + (trim ? w : 0);
            pm  = pm | (1 << b);
            for (int k = 0; k < dur; k++) begin
                int t;
                t = c + k;
                m_exp[0][t] = (k < dur - 1) ? 1 : 0;
                m_exp[1][t] = (k >= 1 + S && k < 1 + S + R) ? 1 : 0;
                m_exp[2][t] = (trim && k == 1 + S + R) ? 1 : 0;
                m_exp[3][t] = 1;
                m_exp[5][t] = b;
                m_exp[6][t] = pm;
                m_exp[7][t] = (trim && !ok && k == dur - 1) ? (fm | (1 << b)) : fm;
                m_wait[t]   = trim && (k >= 2 + S + R) && (k < dur - 1);
            end
            if (trim && !ok) fm = fm | (1 << b);
            if (trim && d_of[b] >= 1) m_tin[c + 1 + S + R + d_of[b]] = 1;
            c = c + dur;
        end
        m_done = c;
        for (int t = c; t < NC; t++) begin
            m_exp[3][t] = (t == c) ? 1 : 0;
            m_exp[4][t] = (t == c) ? 1 : 0;
            m_exp[5][t] = last;
            m_exp[6][t] = pm;
            m_exp[7][t] = fm;
        end
        for (int t = 1; t < NC; t++) begin
            if (spt && !m_wait[t] && $urandom_range(0, 5) == 0) m_tin[t] = 1;
            if (sps && t <= m_done && $urandom_range(0, 7) == 0) m_spst[t] = 1;
        end
    endtask

    // abort_sel: -1 none, -2 random cycle, otherwise the cycle to abort in.
    task automatic run_seq(input string tag, input int nb, input bit trim, input int abort_sel,
                           input bit spt, input bit sps, output int end_cyc, output int n_ack);
        int abort_at;
        int lim;
        int bad_c[8];
        int bad_a[8];
        int bad_e[8];
        int act[8];
        build_model(nb, trim, spt, sps);
        abort_at = (abort_sel == -2) ? int'($urandom_range(2, m_done - 1)) : abort_sel;
        if (abort_at > 0) begin
            for (int t = abort_at + 1; t < NC; t++) begin
                for (int i = 0; i < 5; i++) m_exp[i][t] = 0;
                m_exp[5][t] = -1;
                m_exp[6][t] = 0;
                m_exp[7][t] = m_exp[7][abort_at];
            end
            for (int t = abort_at; t < NC; t++) m_spst[t] = 0;
        end
        lim = (abort_at > 0) ? abort_at + 6 : m_done + 2;
        for (int i = 0; i < 8; i++) bad_c[i] = -1;
        end_cyc = -1;
        n_ack   = 0;
        @(negedge clk);
        start_init = 1'b1;
        n_buses    = CW'(nb);
        osc        = trim;
        end_trim   = 1'b0;
        abort      = 1'b0;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            act[0] = int'(power_bus_en);
            act[1] = int'(rst_bus);
            act[2] = int'(start_trim_ack);
            act[3] = int'(busy);
            act[4] = int'(end_power_init);
            act[5] = int'(power_bus_cnt);
            act[6] = int'(power_mask);
            act[7] = int'(bus_fail_mask);
            for (int i = 0; i < 8; i++) begin
                if (m_exp[i][c] != -1 && act[i] != m_exp[i][c] && bad_c[i] < 0) begin
                    bad_c[i] = c;
                    bad_a[i] = act[i];
                    bad_e[i] = m_exp[i][c];
                end
            end
            if (end_power_init && end_cyc < 0) end_cyc = c;
            if (start_trim_ack) n_ack++;
            start_init = m_spst[c];
            n_buses    = CW'($urandom);
            osc        = 1'($urandom);
            end_trim   = m_tin[c];
            abort      = (c == abort_at);
        end
        start_init = 1'b0;
        end_trim   = 1'b0;
        abort      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bad_c[i] >= 0) begin
                errors++;
                $display("FAIL %s wave %s: cycle %0d got %0h expected %0h",
                         tag, sig_name[i], bad_c[i], bad_a[i], bad_e[i]);
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        int e;
        int na;
        // {nb, trim, d0, drest, none_mask, spt, sps, abort_at, done, pm, fm, acks}
        vecs[0] = '{0, 1'b0, 3, 3, 0, 1'b0, 1'b0, -1, 10, 16'h0001, 0, 0};
        vecs[1] = '{15, 1'b1, 3, 3, 0, 1'b0, 1'b0, -1, 193, 16'hFFFF, 0, 16};
        vecs[2] = '{2, 1'b1, 3, 3, 16'h0002, 1'b0, 1'b0, -1, 55, 16'h0007, 16'h0002, 3};
        vecs[3] = '{1, 1'b1, TO + 1, TO + 2, 0, 1'b1, 1'b0, -1, 61, 16'h0003, 16'h0002, 2};
        vecs[4] = '{7, 1'b1, 3, 3, 16'h0004, 1'b0, 1'b0, 84, -1, 0, 16'h0004, 5};
        vecs[5] = '{31, 1'b0, 3, 3, 0, 1'b0, 1'b1, -1, 145, 16'hFFFF, 0, 0};

        #12;
        chk("reset_outputs", int'({power_bus_cnt, power_bus_en, power_mask, rst_bus,
                                   start_trim_ack, bus_fail_mask, busy, end_power_init}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            for (int b = 0; b < MB; b++)
                d_of[b] = ((vecs[v].none_mask >> b) & 1) != 0 ? 0 :
                          (b == 0 ? vecs[v].d0 : vecs[v].drest);
            run_seq(tag, vecs[v].nb, vecs[v].trim, vecs[v].abort_at, vecs[v].spt, vecs[v].sps,
                    e, na);
            chk({tag, " end_cycle"}, e, vecs[v].exp_done);
            chk({tag, " power_mask"}, int'(power_mask), vecs[v].exp_pm);
            chk({tag, " fail_mask"}, int'(bus_fail_mask), vecs[v].exp_fm);
            chk({tag, " ack_count"}, na, vecs[v].exp_ack);
        end

        for (int it = 0; it < 10; it++) begin
            int nb;
            bit trim;
            int asel;
            nb   = int'($urandom_range(0, 31));
            trim = 1'($urandom);
            asel = ($urandom_range(0, 3) == 0) ? -2 : -1;
            for (int b = 0; b < MB; b++) begin
                int r;
                r = int'($urandom_range(0, 9));
                d_of[b] = (r == 0) ? 0 : (r == 1) ? TO + 1 : (r == 2) ? TO + 2 :
                          int'($urandom_range(1, TO));
            end
            run_seq($sformatf("rand%0d", it), nb, trim, asel, 1'($urandom), 1'($urandom), e, na);
            if (asel == -1) chk($sformatf("rand%0d end_cycle", it), e, m_done);
        end

        // Asynchronous reset in the middle of a TRIM_WAIT.
        @(negedge clk);
        start_init = 1'b1;
        n_buses    = 5'd31;
        osc        = 1'b1;
        @(negedge clk);
        start_init = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_busy_en", int'({busy, power_bus_en, rst_bus}), 3'b110);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({power_bus_cnt, power_bus_en, power_mask, rst_bus,
                                         start_trim_ack, bus_fail_mask, busy, end_power_init}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", int'({busy, power_bus_en}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
